postcode_sender: RTL
====================

# postcode_sender

Initiator end of the TESTREQ/TESTACK POST link. It serialises bytes onto TESTREQ as pulse-coded bit cells and samples TESTACK to detect the adapter and read back one bit per cell. The block sits in the host-emulator build and in the adapter verification bench, where it drives the POST adapter in place of a real machine. Its user side is a byte-wide valid/ready pair.

## Interface
Parameters:
- PULSE_W, 6: TESTREQ high time per pulse, in refclk cycles (0.5 us at 12 MHz).
- PULSE_GAP, 24: low time between the two pulses of a '1' cell.
- ACK_SAMPLE, 12: cycles after the last pulse's falling edge at which TESTACK is sampled.
- CELL_GAP, 240: low time closing a cell. Must exceed the adapter's 15 us timeout (180 cycles).
- MAX_RETRY, 15: probe attempts before declaring no adapter.

Ports:
- refclk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- tx_data, in, 8: byte to send.
- tx_valid, in, 1: request to send tx_data.
- tx_ready, out, 1: idle and able to accept a byte.
- testreq, out, 1: pulse line to the adapter.
- testack, in, 1: adapter response. Open-drain high or float; a pull-down reads 0.
- rx_data, out, 8: TESTACK bits returned during the last byte.
- rx_valid, out, 1: one-cycle strobe when rx_data updates.
- no_adapter, out, 1: one-cycle strobe when the probe limit is exhausted.

## Operation
- Reset values: testreq=0, tx_ready=1, rx_data=0, rx_valid=0, no_adapter=0. All counters clear and the FSM is in IDLE. Reset asserted mid-cell drops testreq in the next cycle and abandons the byte without strobes.
- Handshake: a transfer is accepted on a cycle with tx_valid & tx_ready. tx_data is latched into a shift register, the retry count clears, and tx_ready falls the next cycle.
- States:
  - IDLE.
  - PROBE_HI: PULSE_W cycles.
  - PROBE_WAIT: ACK_SAMPLE cycles, then sample TESTACK.
  - PROBE_GAP: CELL_GAP cycles.
  - P1_HI: PULSE_W cycles.
  - GAP: PULSE_GAP cycles.
  - P2_HI: PULSE_W cycles.
  - SAMPLE_WAIT: ACK_SAMPLE cycles.
  - CELL_LO: CELL_GAP cycles.
- Probe: a single pulse, then TESTACK is sampled.
  - Sampled 1: go to PROBE_GAP, then to P1_HI for bit 0.
  - Sampled 0: the retry count increments. On reaching MAX_RETRY, pulse no_adapter and return to IDLE with tx_ready=1. Otherwise go to PROBE_GAP and re-probe.
- Bit cells are sent LSB first.
  - Bit=0: path is P1_HI → SAMPLE_WAIT. One pulse.
  - Bit=1: path is P1_HI → GAP → P2_HI → SAMPLE_WAIT. Two pulses.
  - At the end of SAMPLE_WAIT, TESTACK is shifted into rx_data bit [n]. The FSM then enters CELL_LO.
  - After CELL_LO of bit 7: rx_valid pulses for 1 cycle, tx_ready rises the same cycle, and the FSM returns to IDLE.
  - Otherwise CELL_LO goes to P1_HI for the next bit.
- testreq is high only in PROBE_HI, P1_HI and P2_HI. It is driven from a register, so it is glitch-free.
- tx_valid and tx_data are ignored while tx_ready=0.
- Phase counter: 9 bits, loaded with (duration−1) on state entry, counting down to 0. A parameter value of 0 is illegal; elaboration checks all durations ≥1.
- Retry counter: 4 bits, saturating.
- The bit index is 3 bits. No wrap: the FSM leaves after index 7.
- TESTACK passes through a 2-flop synchroniser before any sampling. The ACK_SAMPLE count includes that latency.

## Timing
- Accept at cycle 0 → testreq rises at cycle 1 (PROBE_HI entry).
- Probe cell length: PULSE_W+ACK_SAMPLE+CELL_GAP = 258 cycles.
- '0' cell: 258 cycles, the same as a probe. '1' cell: 2·PULSE_W+PULSE_GAP+ACK_SAMPLE+CELL_GAP = 288 cycles.
- Byte latency (successful first probe) = 1 + 258 + 8·258 + 30·popcount(tx_data). For 0x00 this is 2323 cycles.
- The gap between consecutive bytes is bounded only by tx_valid. Back-to-back acceptance is legal on the cycle tx_ready rises.

## Test plan
- Reset mid-P2_HI → testreq=0 next cycle, tx_ready=1, no rx_valid/no_adapter ever fires for that byte.
- testack held 0, send 0x55 → exactly 15 probe pulses 258 cycles apart, then a no_adapter strobe and tx_ready=1. No data pulses appear.
- testack held 1, send 0xA5 → 1 probe pulse, then pulse counts 2,1,2,1,1,2,1,2 (LSB first: bits 1,0,1,0,0,1,0,1). rx_valid fires with rx_data=0xFF after 2323+120 cycles.
- Bench adapter model drives testack=bit k of 0x3C during cell k, send 0x00 → rx_data=0x3C. Every cell is 258 cycles.
- Probe fails twice, then testack rises; send 0xFF → 3 probes, then 8 double-pulse cells. Measured pulse width is 6 and gap 24; every TESTREQ low period between cells is ≥240 cycles.
- Drive tx_valid the same cycle rx_valid fires with 0x01 → the second byte is accepted on that cycle and testreq rises on the next.

Source files
------------

// File: rtl/postcode_sender.sv
// postcode_sender
//
// Initiator end of the TESTREQ/TESTACK POST link. Each byte taken from the
// user side is preceded by a probe cell (one pulse) that detects the adapter.
// The byte is then sent LSB first as pulse-coded cells: one pulse for a '0',
// two pulses for a '1'. TESTACK is sampled once per cell, and the sampled
// bits are returned as rx_data when the byte completes.
//
// Ports
//   refclk      in   1  sole clock
//   reset       in   1  synchronous, active-high
//   tx_data     in   8  byte to send
//   tx_valid    in   1  request to send tx_data
//   tx_ready    out  1  idle and able to accept a byte
//   testreq     out  1  pulse line to the adapter (registered)
//   testack     in   1  adapter response (asynchronous, synchronised here)
//   rx_data     out  8  TESTACK bits returned during the last byte
//   rx_valid    out  1  one-cycle strobe when rx_data updates
//   no_adapter  out  1  one-cycle strobe when the probe limit is exhausted

module postcode_sender #(
    parameter int PULSE_W    = 6,
    parameter int PULSE_GAP  = 24,
    parameter int ACK_SAMPLE = 12,
    parameter int CELL_GAP   = 240,
    parameter int MAX_RETRY  = 15
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       testreq,
    input  logic       testack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       no_adapter
);

    // The phase counter is 9 bits wide, so every duration must fit in 1..512.
    // The retry counter is 4 bits wide, so the probe limit must fit in 1..15.
    if (PULSE_W < 1 || PULSE_W > 512) begin : g_bad_pulse_w
        $error("postcode_sender: PULSE_W must be in 1..512");
    end
    if (PULSE_GAP < 1 || PULSE_GAP > 512) begin : g_bad_pulse_gap
        $error("postcode_sender: PULSE_GAP must be in 1..512");
    end
    if (ACK_SAMPLE < 1 || ACK_SAMPLE > 512) begin : g_bad_ack_sample
        $error("postcode_sender: ACK_SAMPLE must be in 1..512");
    end
    if (CELL_GAP < 1 || CELL_GAP > 512) begin : g_bad_cell_gap
        $error("postcode_sender: CELL_GAP must be in 1..512");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
        $error("postcode_sender: MAX_RETRY must be in 1..15");
    end

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] PROBE_HI    = 4'd1;
    localparam logic [3:0] PROBE_WAIT  = 4'd2;
    localparam logic [3:0] PROBE_GAP   = 4'd3;
    localparam logic [3:0] P1_HI       = 4'd4;
    localparam logic [3:0] GAP         = 4'd5;
    localparam logic [3:0] P2_HI       = 4'd6;
    localparam logic [3:0] SAMPLE_WAIT = 4'd7;
    localparam logic [3:0] CELL_LO     = 4'd8;

    // Phase counter reload values: a state lasting N cycles loads N-1.
    localparam logic [8:0] PULSE_W_LD    = 9'(PULSE_W - 1);
    localparam logic [8:0] PULSE_GAP_LD  = 9'(PULSE_GAP - 1);
    localparam logic [8:0] ACK_SAMPLE_LD = 9'(ACK_SAMPLE - 1);
    localparam logic [8:0] CELL_GAP_LD   = 9'(CELL_GAP - 1);
    localparam logic [4:0] RETRY_LIMIT   = 5'(MAX_RETRY);

    logic [3:0] state;
    logic [3:0] state_next;
    logic [8:0] phase;
    logic [8:0] phase_next;
    logic [3:0] retry_cnt;
    logic [2:0] bit_idx;
    logic       linked;      // current byte has seen a successful probe
    logic [7:0] tx_shift;    // bit 0 is the bit of the cell in progress
    logic [7:0] rx_shift;
    logic       ack_meta;
    logic       ack_sync;

    logic phase_done;
    logic accept;
    logic probe_ok;
    logic probe_fail;
    logic give_up;
    logic bit_sample;
    logic cell_advance;
    logic byte_done;

    assign phase_done = (phase == 9'd0);
    assign accept     = tx_valid && tx_ready;

    always_comb begin
        state_next   = state;
        phase_next   = phase_done ? phase : phase - 9'd1;
        probe_ok     = 1'b0;
        probe_fail   = 1'b0;
        give_up      = 1'b0;
        bit_sample   = 1'b0;
        cell_advance = 1'b0;
        byte_done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = PROBE_HI;
                    phase_next = PULSE_W_LD;
                end
            end
            PROBE_HI: begin
                if (phase_done) begin
                    state_next = PROBE_WAIT;
                    phase_next = ACK_SAMPLE_LD;
                end
            end
            PROBE_WAIT: begin
                if (phase_done) begin
                    if (ack_sync) begin
                        probe_ok   = 1'b1;
                        state_next = PROBE_GAP;
                        phase_next = CELL_GAP_LD;
                    end else begin
                        probe_fail = 1'b1;
                        // The attempt just made is the one that reaches the limit:
                        // give up without closing the cell.
                        if (({1'b0, retry_cnt} + 5'd1) >= RETRY_LIMIT) begin
                            give_up    = 1'b1;
                            state_next = IDLE;
                            phase_next = 9'd0;
                        end else begin
                            state_next = PROBE_GAP;
                            phase_next = CELL_GAP_LD;
                        end
                    end
                end
            end
            PROBE_GAP: begin
                if (phase_done) begin
                    state_next = linked ? P1_HI : PROBE_HI;
                    phase_next = PULSE_W_LD;
                end
            end
            P1_HI: begin
                if (phase_done) begin
                    if (tx_shift[0]) begin
                        state_next = GAP;
                        phase_next = PULSE_GAP_LD;
                    end else begin
                        state_next = SAMPLE_WAIT;
                        phase_next = ACK_SAMPLE_LD;
                    end
                end
            end
            GAP: begin
                if (phase_done) begin
                    state_next = P2_HI;
                    phase_next = PULSE_W_LD;
                end
            end
            P2_HI: begin
                if (phase_done) begin
                    state_next = SAMPLE_WAIT;
                    phase_next = ACK_SAMPLE_LD;
                end
            end
            SAMPLE_WAIT: begin
                if (phase_done) begin
                    bit_sample = 1'b1;
                    state_next = CELL_LO;
                    phase_next = CELL_GAP_LD;
                end
            end
            CELL_LO: begin
                if (phase_done) begin
                    if (bit_idx == 3'd7) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                        phase_next = 9'd0;
                    end else begin
                        cell_advance = 1'b1;
                        state_next   = P1_HI;
                        phase_next   = PULSE_W_LD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = 9'd0;
            end
        endcase
    end

    // Control state and registered outputs. testreq and tx_ready are decoded
    // from the next state so they line up exactly with the state they describe.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 9'd0;
            retry_cnt  <= 4'd0;
            bit_idx    <= 3'd0;
            linked     <= 1'b0;
            testreq    <= 1'b0;
            tx_ready   <= 1'b1;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            no_adapter <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            testreq    <= (state_next == PROBE_HI) || (state_next == P1_HI) ||
                          (state_next == P2_HI);
            tx_ready   <= (state_next == IDLE);
            rx_valid   <= byte_done;
            no_adapter <= give_up;
            if (byte_done) begin
                rx_data <= rx_shift;
            end
            if (accept) begin
                retry_cnt <= 4'd0;
            end else if (probe_fail && retry_cnt != 4'hF) begin
                retry_cnt <= retry_cnt + 4'd1;
            end
            if (accept) begin
                bit_idx <= 3'd0;
            end else if (cell_advance) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (accept) begin
                linked <= 1'b0;
            end else if (probe_ok) begin
                linked <= 1'b1;
            end
        end
    end

    // Datapath: byte shift register, returned bits and the TESTACK synchroniser.
    always_ff @(posedge refclk) begin
        ack_meta <= testack;
        ack_sync <= ack_meta;
        if (accept) begin
            tx_shift <= tx_data;
        end else if (cell_advance) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
        if (bit_sample) begin
            rx_shift[bit_idx] <= ack_sync;
        end
    end

endmodule
